// File: rtl/core_issue.sv
// rtl/core_issue.sv - operand-issue stage: forwarding mux, load-use bubbles, output pipeline register
//
// Ports
//   clk, rst                      core clock, asynchronous active-high reset
//   dec_valid / dec_ready         decoded-instruction handshake
//   dec_op, dec_rd, dec_rs1,      decoded ALU op, destination and source indices
//   dec_rs2, dec_imm, dec_use_imm immediate and its select for the b operand
//   dec_wb, dec_load              instruction writes rd / instruction is a load
//   rf_ra, rf_rb                  register file read addresses
//   rf_qa, rf_qb                  register file read data (combinational)
//   alu_q                         ALU result of the instruction held in the output register
//   wb_valid, wb_rd, wb_q         writeback bus
//   ex_valid / ex_ready           output register handshake towards the ALU
//   ex_op, ex_a, ex_b             ALU operation and operands
//   ex_rd, ex_wb, ex_load         destination and flags carried downstream
//   flush                         kills the held instruction, blocks acceptance
//   stall_cnt                     saturating count of stalled cycles
module core_issue #(
    parameter int W   = 16,
    parameter int R   = 16,
    parameter int RW  = $clog2(R),
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  logic [OPW-1:0] dec_op,
    input  logic [RW-1:0]  dec_rd,
    input  logic [RW-1:0]  dec_rs1,
    input  logic [RW-1:0]  dec_rs2,
    input  logic [W-1:0]   dec_imm,
    input  logic           dec_use_imm,
    input  logic           dec_wb,
    input  logic           dec_load,
    output logic [RW-1:0]  rf_ra,
    output logic [RW-1:0]  rf_rb,
    input  logic [W-1:0]   rf_qa,
    input  logic [W-1:0]   rf_qb,
    input  logic [W-1:0]   alu_q,
    input  logic           wb_valid,
    input  logic [RW-1:0]  wb_rd,
    input  logic [W-1:0]   wb_q,
    output logic           ex_valid,
    input  logic           ex_ready,
    output logic [OPW-1:0] ex_op,
    output logic [W-1:0]   ex_a,
    output logic [W-1:0]   ex_b,
    output logic [RW-1:0]  ex_rd,
    output logic           ex_wb,
    output logic           ex_load,
    input  logic           flush,
    output logic [15:0]    stall_cnt
);

    // Op encoding shared with the ALU: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
    localparam logic [OPW-1:0] ALU_AND = OPW'(2);

    logic         alu_fwd_ok;
    logic         rs1_alu_hit;
    logic         rs2_alu_hit;
    logic         rs1_wb_hit;
    logic         rs2_wb_hit;
    logic         hazard;
    logic         take;
    logic         stall_evt;
    logic [W-1:0] opnd_a;
    logic [W-1:0] opnd_b;

    assign rf_ra = dec_rs1;
    assign rf_rb = dec_rs2;

    // A load's result is not on alu_q, so only non-load writers may forward from the ALU.
    assign alu_fwd_ok  = ex_valid && ex_wb && !ex_load;
    assign rs1_alu_hit = alu_fwd_ok && (ex_rd == dec_rs1);
    assign rs2_alu_hit = alu_fwd_ok && (ex_rd == dec_rs2);
    assign rs1_wb_hit  = wb_valid && (wb_rd == dec_rs1);
    assign rs2_wb_hit  = wb_valid && (wb_rd == dec_rs2);

    // r0 is hardwired to zero and excluded from every match, including hazards.
    assign hazard = ex_valid && ex_load && ex_wb && (ex_rd != '0) &&
                    ((ex_rd == dec_rs1) || (!dec_use_imm && (ex_rd == dec_rs2)));

    assign dec_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign take      = dec_valid && dec_ready;
    assign stall_evt = dec_valid && !dec_ready && !flush;

    // Forwarding priority: ALU result, then writeback, then register file.
    // alu_q feeds this mux combinationally; this is the stage's critical path.
    always_comb begin
        opnd_a = rf_qa;
        if (dec_rs1 == '0) begin
            opnd_a = '0;
        end else if (rs1_alu_hit) begin
            opnd_a = alu_q;
        end else if (rs1_wb_hit) begin
            opnd_a = wb_q;
        end
    end

    always_comb begin
        opnd_b = rf_qb;
        if (dec_use_imm) begin
            opnd_b = dec_imm;
        end else if (dec_rs2 == '0) begin
            opnd_b = '0;
        end else if (rs2_alu_hit) begin
            opnd_b = alu_q;
        end else if (rs2_wb_hit) begin
            opnd_b = wb_q;
        end
    end

    // Output pipeline register. Data fields only change on a transfer; a bubble
    // or flush just clears ex_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= ALU_AND;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
            ex_wb    <= 1'b0;
            ex_load  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (take) begin
            ex_valid <= 1'b1;
            ex_op    <= dec_op;
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_rd    <= dec_rd;
            ex_wb    <= dec_wb;
            ex_load  <= dec_load;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_core_issue.sv
// tb/tb_core_issue.sv - scoreboard bench for core_issue
module tb_core_issue;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rd;
        logic        wb;
        logic        load;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [2:0]  dec_op = '0;
    logic [3:0]  dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic [15:0] dec_imm = '0;
    logic        dec_use_imm = 1'b0, dec_wb = 1'b0, dec_load = 1'b0;
    logic [3:0]  rf_ra, rf_rb;
    logic [15:0] rf_qa = '0, rf_qb = '0;
    logic [15:0] alu_q;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic [15:0] wb_q = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [2:0]  ex_op;
    logic [15:0] ex_a, ex_b;
    logic [3:0]  ex_rd;
    logic        ex_wb, ex_load;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    core_issue dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_wb(dec_wb), .dec_load(dec_load),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_qa(rf_qa), .rf_qb(rf_qb),
        .alu_q(alu_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_q(wb_q),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_load(ex_load),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    // Behavioural ALU standing in for the downstream stage.
    always_comb begin
        case (ex_op)
            OP_ADD:  alu_q = ex_a + ex_b;
            OP_SUB:  alu_q = ex_a - ex_b;
            OP_AND:  alu_q = ex_a & ex_b;
            OP_OR:   alu_q = ex_a | ex_b;
            OP_XOR:  alu_q = ex_a ^ ex_b;
            default: alu_q = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [15:0] imm, input logic use_imm,
                       input logic wb, input logic load);
        dec_valid   = 1'b1;
        dec_op      = op;
        dec_rd      = rd;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_imm     = imm;
        dec_use_imm = use_imm;
        dec_wb      = wb;
        dec_load    = load;
    endtask

    task automatic expect_out(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] rd, input logic wb, input logic load);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.wb = wb; e.load = load;
        sb.push_back(e);
    endtask

    // Every instruction consumed downstream is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ex_op", 32'(ex_op), 32'(e.op));
                chk("ex_a", 32'(ex_a), 32'(e.a));
                chk("ex_b", 32'(ex_b), 32'(e.b));
                chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                chk("ex_wb", 32'(ex_wb), 32'(e.wb));
                chk("ex_load", 32'(ex_load), 32'(e.load));
            end
        end
    end

    initial begin
        exp_t junk;
        tick();
        tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_op", 32'(ex_op), 32'(OP_AND));
        chk("rst_ex_a", 32'(ex_a), 32'd0);
        chk("rst_ex_b", 32'(ex_b), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_dec_ready", 32'(dec_ready), 32'd1);

        // ADD r1 = r3 + r4 from the register file
        ex_ready = 1'b1;
        rf_qa = 16'd3; rf_qb = 16'd4;
        put(OP_ADD, 4'd1, 4'd3, 4'd4, 16'h0, 1'b0, 1'b1, 1'b0);
        expect_out(OP_ADD, 16'd3, 16'd4, 4'd1, 1'b1, 1'b0);
        tick();
        chk("lat_ex_valid", 32'(ex_valid), 32'd1);
        chk("lat_stall", 32'(stall_cnt), 32'd0);

        // ADD r2 = r1 + r1: alu_q (7) beats a matching writeback and stale rf
        rf_qa = 16'd0; rf_qb = 16'd0;
        wb_valid = 1'b1; wb_rd = 4'd1; wb_q = 16'hBEEF;
        put(OP_ADD, 4'd2, 4'd1, 4'd1, 16'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("fwd_dec_ready", 32'(dec_ready), 32'd1);
        expect_out(OP_ADD, 16'h0007, 16'h0007, 4'd2, 1'b1, 1'b0);
        tick();
        wb_valid = 1'b0;

        // Load r5 = [r6 + 4]; rs2 matches ex_rd but the immediate is used
        rf_qa = 16'h0100;
        put(OP_ADD, 4'd5, 4'd6, 4'd2, 16'd4, 1'b1, 1'b1, 1'b1);
        expect_out(OP_ADD, 16'h0100, 16'd4, 4'd5, 1'b1, 1'b1);
        tick();

        // Load-use: one bubble, then the operand arrives through writeback
        rf_qa = 16'h0000; rf_qb = 16'h0011;
        put(OP_ADD, 4'd7, 4'd5, 4'd8, 16'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu_dec_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_stall", 32'(stall_cnt), 32'd1);
        wb_valid = 1'b1; wb_rd = 4'd5; wb_q = 16'h1234;
        #1;
        chk("lu_dec_ready2", 32'(dec_ready), 32'd1);
        expect_out(OP_ADD, 16'h1234, 16'h0011, 4'd7, 1'b1, 1'b0);
        tick();
        wb_valid = 1'b0;
        chk("lu_stall_after", 32'(stall_cnt), 32'd1);

        // Backpressure for three cycles with an instruction waiting
        ex_ready = 1'b0;
        rf_qa = 16'h0050; rf_qb = 16'h0010;
        put(OP_SUB, 4'd8, 4'd3, 4'd4, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_dec_ready", 32'(dec_ready), 32'd0);
            chk("bp_ex_valid", 32'(ex_valid), 32'd1);
            chk("bp_ex_a", 32'(ex_a), 32'h1234);
            tick();
        end
        chk("bp_stall", 32'(stall_cnt), 32'd4);
        ex_ready = 1'b1;
        #1;
        chk("bp_release", 32'(dec_ready), 32'd1);
        expect_out(OP_SUB, 16'h0050, 16'h0010, 4'd8, 1'b1, 1'b0);
        tick();

        // r0 sources ignore a writeback to r0
        rf_qa = 16'h0; rf_qb = 16'h0;
        wb_valid = 1'b1; wb_rd = 4'd0; wb_q = 16'hFFFF;
        put(OP_OR, 4'd9, 4'd0, 4'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        expect_out(OP_OR, 16'h0000, 16'h0000, 4'd9, 1'b1, 1'b0);
        tick();
        wb_valid = 1'b0;

        // Flush kills the held instruction and accepts nothing
        ex_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_dec_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_stall", 32'(stall_cnt), 32'd4);
        junk = sb.pop_front();
        flush = 1'b0;
        dec_valid = 1'b0;

        // Reset in the middle of a hold
        ex_ready = 1'b1;
        rf_qa = 16'hF0F0; rf_qb = 16'h0FF0;
        put(OP_AND, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0, 1'b1, 1'b0);
        expect_out(OP_AND, 16'hF0F0, 16'h0FF0, 4'd3, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        dec_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_a", 32'(ex_a), 32'd0);
        junk = sb.pop_front();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(dec_ready), 32'd1);

        // Saturation of the stall counter
        ex_ready = 1'b1;
        rf_qa = 16'hAAAA; rf_qb = 16'h5555;
        put(OP_XOR, 4'd4, 4'd1, 4'd2, 16'h0, 1'b0, 1'b1, 1'b0);
        expect_out(OP_XOR, 16'hAAAA, 16'h5555, 4'd4, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        dec_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        tick();
        chk("drain_ex_valid", 32'(ex_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_issue.md
# core_issue

Operand-issue stage of the core, directly upstream of the ALU. It accepts one decoded instruction per cycle and reads its source operands from the register file. Operands are resolved through a forwarding network (ALU result, then writeback, then register file), and the op plus both operands are held in an output pipeline register that drives the ALU inputs. It also detects load-use hazards, inserts bubbles, honours downstream backpressure and flush, and keeps a saturating stall counter.

## Interface

- W, 16, datapath width; matches ALU width
- R, 16, architectural register count; index width RW = $clog2(R)

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  stage accepts instruction this cycle
- dec_op  in  alu_op  ALU operation
- dec_rd, dec_rs1, dec_rs2  in  RW  destination / source register indices
- dec_imm  in  W  immediate
- dec_use_imm  in  1  b operand = dec_imm instead of rs2
- dec_wb  in  1  instruction writes rd
- dec_load  in  1  instruction is a load; result comes late, not from ALU
- rf_ra, rf_rb  out  RW  register file read addresses (= dec_rs1, dec_rs2)
- rf_qa, rf_qb  in  W  register file read data, combinational
- alu_q  in  W  ALU result for the instruction currently in the output register
- wb_valid  in  1  writeback this cycle
- wb_rd  in  RW  writeback register
- wb_q  in  W  writeback data
- ex_valid  out  1  output register holds a valid instruction
- ex_ready  in  1  downstream consumes the output this cycle
- ex_op  out  alu_op  to ALU op
- ex_a, ex_b  out  W  to ALU a, b
- ex_rd  out  RW  destination register
- ex_wb, ex_load  out  1  flags carried downstream
- flush  in  1  kill the in-flight instruction
- stall_cnt  out  16  saturating count of stalled cycles

## Operation

- Register 0 reads as 0. It is never matched by forwarding or hazard logic.
- Operand resolution applies to each source s (rs1 always; rs2 only when dec_use_imm=0), in strict priority order:
  1. alu_q, if ex_valid && ex_wb && !ex_load && ex_rd==s && s!=0
  2. wb_q, if wb_valid && wb_rd==s && s!=0
  3. rf_qa / rf_qb
- When dec_use_imm=1, b = dec_imm and rs2 is ignored for forwarding and hazard detection.
- Hazard (load-use): hazard = ex_valid && ex_load && ex_wb && ex_rd!=0 && (ex_rd==rs1 || (!dec_use_imm && ex_rd==rs2)).
- dec_ready = !flush && !hazard && (!ex_valid || ex_ready).
- Transfer: on dec_valid && dec_ready, the resolved op, a, b, rd, wb and load are captured into the output register and ex_valid is set to 1.
- Bubble: on ex_ready with no transfer (hazard, or dec_valid=0), ex_valid goes to 0. Data fields hold their values.
- Hold: ex_valid && !ex_ready keeps the output register unchanged. dec_ready=0 in this case.
- Flush: ex_valid goes to 0 next cycle and nothing is accepted that cycle. Flush overrides every other condition.
- stall_cnt increments on every cycle with dec_valid && !dec_ready && !flush. It saturates at 0xFFFF and never wraps.

## Timing

- Reset (async, immediate):
  - ex_valid=0, ex_op=ALU_AND encoding, ex_a=0, ex_b=0, ex_rd=0, ex_wb=0, ex_load=0, stall_cnt=0.
  - dec_ready is combinational and equals 1 during reset release only if flush=0.
- Latency: an instruction accepted in cycle N appears on ex_* in cycle N+1, one cycle after acceptance.
- Back-to-back dependent ALU ops issue without a stall via the alu_q path.
- Load-use costs exactly one bubble per ex_ready cycle while the load occupies the output register. After the load moves on, the operand arrives via wb_q or the register file.
- Simultaneous events:
  - alu_q and wb_q both match: alu_q wins.
  - flush and hazard together: flush behaviour applies.
  - Reset mid-hold discards the held instruction.
- alu_q is combinational from ex_a/ex_b/ex_op. The forward path is alu → issue mux → output register and is the critical path; no registering is allowed on it.

## Test plan

- Reset, then issue ADD r1 with rf_qa=3, rf_qb=4, followed by ex_ready=1 -> next cycle ex_valid=1, ex_op=ADD, ex_a=3, ex_b=4, stall_cnt=0.
- ADD r2 = r1+r1 directly after an instruction writing r1 (alu_q=0x0007), with rf returning stale 0 -> ex_a=ex_b=0x0007 and no stall.
- Load to r5 in output register; next instruction uses r5 -> one cycle with dec_ready=0 and ex_valid=0; then the instruction issues using wb_q=0x1234; stall_cnt=1.
- ex_ready=0 for 3 cycles with dec_valid=1 -> ex_* stable, dec_ready=0, stall_cnt=3; release -> queued instruction issues next cycle.
- Source r0 with wb_valid=1, wb_rd=0, wb_q=0xFFFF -> operand 0.
- flush asserted while ex_valid=1 -> ex_valid=0 next cycle, no instruction accepted that cycle; also check stall_cnt preloaded near 0xFFFF saturates at 0xFFFF.
